// File: rtl/binomial_transform_seq.sv
// binomial_transform_seq
// Streams in N samples of W bits, computes iterated forward differences in
// place (one subtraction per clock) and streams out either the single
// (N-1)th-order difference (mode 0) or the whole binomial-transform
// sequence D^0 a0 .. D^(N-1) a0 (mode 1).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     sample handshake, in_data is the sample
//   mode                  0 = single result, 1 = full sequence; taken with a0
//   out_valid/out_ready   result handshake, out_data is the result beat
//   out_last              high on the final beat of a block
//   busy                  high while computing or presenting results
module binomial_transform_seq #(
  parameter int N = 10,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_COMPUTE,
    S_OUTPUT
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] p_q, p_d;
  logic [IW-1:0] j_q, j_d;
  logic [IW-1:0] k_q, k_d;
  logic          mode_q, mode_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_last_q, out_last_d;

  logic [W-1:0]  smp_q [N];
  logic [W-1:0]  res_q [N];

  logic          accept;
  logic [W-1:0]  diff;

  assign accept = in_valid && (state_q == S_LOAD);
  assign diff   = smp_q[j_q + 1'b1] - smp_q[j_q];

  // Sample and result storage: contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      smp_q[cnt_q] <= in_data;
      if (cnt_q == '0) res_q[0] <= in_data;
    end else if (state_q == S_COMPUTE) begin
      smp_q[j_q] <= diff;
      if (j_q == '0) res_q[p_q] <= diff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      cnt_q      <= '0;
      p_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      mode_q     <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      j_q        <= j_d;
      k_q        <= k_d;
      mode_q     <= mode_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    j_d        = j_q;
    k_d        = k_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    unique case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (cnt_q == '0) mode_d = mode;
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (N == 1) begin
              state_d    = S_OUTPUT;
              k_d        = '0;
              out_data_d = in_data;
              out_last_d = 1'b1;
            end else begin
              state_d = S_COMPUTE;
              p_d     = IW'(1);
              j_d     = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        if (j_q == LAST - p_q) begin
          if (p_q == LAST) begin
            // res[N-1] is being written this cycle, so mode 0 forwards diff.
            state_d    = S_OUTPUT;
            k_d        = '0;
            out_data_d = mode_q ? res_q[0] : diff;
            out_last_d = !mode_q;
          end else begin
            p_d = p_q + 1'b1;
            j_d = '0;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d    = S_LOAD;
            k_d        = '0;
            out_data_d = '0;
            out_last_d = 1'b0;
          end else begin
            k_d        = k_q + 1'b1;
            out_data_d = res_q[k_q + 1'b1];
            out_last_d = ((k_q + 1'b1) == LAST);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_OUTPUT);
  assign busy      = (state_q != S_LOAD);
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_binomial_transform_seq.sv
module tb_binomial_transform_seq;
  localparam int N = 10;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  binomial_transform_seq #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  typedef struct {
    logic         mode;
    logic [W-1:0] din [N];
    int           nbeats;
    logic [W-1:0] exp [N];
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Feeds one block (mode toggled after a0 and junk offered during compute),
  // checks latency, optionally holds out_ready low, then drains all beats.
  task automatic run_block(input int idx, input int hold);
    int lat;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = tbl[idx].din[i];
      mode     = (i == 0) ? tbl[idx].mode : ~tbl[idx].mode;
      check($sformatf("v%0d_ready_s%0d", idx, i), {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_data = 16'hDEAD;
    mode    = ~tbl[idx].mode;
    check($sformatf("v%0d_compute_flags", idx), {29'd0, in_ready, busy, out_valid}, 32'b010);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check($sformatf("v%0d_latency", idx), lat, 32'd46);
    if (!out_valid) return;
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      check($sformatf("v%0d_hold%0d", idx, h),
            {13'd0, out_valid, in_ready, out_last, out_data},
            {13'd0, 1'b1, 1'b0, (tbl[idx].nbeats == 1), tbl[idx].exp[0]});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int b = 0; b < tbl[idx].nbeats; b++) begin
      check($sformatf("v%0d_beat%0d", idx, b),
            {14'd0, out_valid, out_last, out_data},
            {14'd0, 1'b1, (b == tbl[idx].nbeats - 1), tbl[idx].exp[b]});
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check($sformatf("v%0d_done", idx), {29'd0, out_valid, in_ready, busy}, 32'b010);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      tbl[0].din[i] = W'(i);
      tbl[1].din[i] = W'(i);
      tbl[2].din[i] = W'(i * i);
      tbl[3].din[i] = W'(1 << i);
      tbl[4].din[i] = W'(1 << i);
      tbl[5].din[i] = (i % 2 == 1) ? 16'h8000 : 16'h0000;
      tbl[6].din[i] = (i == 0) ? 16'd1 : 16'd0;
    end
    tbl[0].mode = 1'b1; tbl[0].nbeats = 10;
    tbl[0].exp  = '{16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[1].mode = 1'b0; tbl[1].nbeats = 1;
    tbl[1].exp  = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[2].mode = 1'b1; tbl[2].nbeats = 10;
    tbl[2].exp  = '{16'd0, 16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[3].mode = 1'b0; tbl[3].nbeats = 1;
    tbl[3].exp  = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[4].mode = 1'b1; tbl[4].nbeats = 10;
    tbl[4].exp  = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
    tbl[5].mode = 1'b1; tbl[5].nbeats = 10;
    tbl[5].exp  = '{16'h0000, 16'h8000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    // Impulse at a0: D^k a0 = (-1)^k, wrapping to 0xFFFF for odd k.
    tbl[6].mode = 1'b1; tbl[6].nbeats = 10;
    tbl[6].exp  = '{16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001,
                    16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF};

    #1;
    check("reset_state", {12'd0, in_ready, out_valid, busy, out_last, out_data},
          {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) run_block(v, 0);

    // Backpressure: ramp in mode 1 with out_ready low for 20 cycles.
    run_block(0, 20);

    // Reset in the 20th compute cycle aborts the block.
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      mode     = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
    end
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_flags", {12'd0, in_ready, out_valid, busy, out_last, out_data},
          {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_block(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
